// File: rtl/bin_map_scheduler_if.sv
// rtl/bin_map_scheduler_if.sv - cell stream, reader lock and row-read bus of the bin map scheduler
interface bin_map_scheduler_if #(
  parameter int WIDTH  = 40,
  parameter int ROW_AW = 7
);
  logic              frame_start;
  logic              cell_valid;
  logic              cell_bin;
  logic              rd_lock;
  logic              rd_req;
  logic [ROW_AW-1:0] rd_row;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic              map_ready;
  logic              frame_done;
  logic              frame_drop;

  modport master (
    output frame_start, cell_valid, cell_bin, rd_lock, rd_req, rd_row,
    input  rd_valid, rd_data, map_ready, frame_done, frame_drop
  );

  modport slave (
    input  frame_start, cell_valid, cell_bin, rd_lock, rd_req, rd_row,
    output rd_valid, rd_data, map_ready, frame_done, frame_drop
  );
endinterface

// File: rtl/bin_map_scheduler.sv
// rtl/bin_map_scheduler.sv - ping-pong bank controller for the compressed binary target map
// Packs cell bins into row words in one bank while the reader owns the other; swaps on unlocked commit.
module bin_map_scheduler #(
  parameter int WIDTH  = 40,
  parameter int ROWS   = 72,
  parameter int ROW_AW = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  bin_map_scheduler_if.slave bus
);
  localparam int COL_AW = $clog2(WIDTH);
  localparam logic [COL_AW-1:0] LAST_COL = COL_AW'(WIDTH - 1);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [COL_AW-1:0] col;
  logic [ROW_AW-1:0] row;
  logic [WIDTH-1:0]  row_word;
  logic [WIDTH-1:0]  cell_word;
  logic              wr_bank, rd_bank;
  logic              map_ready_q, frame_done_q, frame_drop_q;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic              take_cell, wr_en, do_swap, do_drop;

  logic [WIDTH-1:0]  mem0 [ROWS];
  logic [WIDTH-1:0]  mem1 [ROWS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.frame_start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (wr_en && row == LAST_ROW) state_nxt = COMMIT;
        COMMIT:  if (!bus.rd_lock) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // frame_start outranks both the last cell and the commit, so that frame is lost.
  always_comb begin
    take_cell = (state == FILL) && bus.cell_valid && !bus.frame_start;
    wr_en     = take_cell && (col == LAST_COL);
    do_swap   = (state == COMMIT) && !bus.rd_lock && !bus.frame_start;
    do_drop   = (state == COMMIT) && bus.frame_start;
    cell_word = row_word;
    cell_word[col] = bus.cell_bin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      row_word     <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b1;
      map_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      frame_done_q <= do_swap;
      frame_drop_q <= do_drop;
      if (bus.frame_start) begin
        col <= '0;
        row <= '0;
      end else if (take_cell) begin
        row_word <= cell_word;
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (do_swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        map_ready_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[row] <= cell_word;
      else         mem0[row] <= cell_word;
    end
  end

  // rd_bank is sampled in the request cycle, so a read during the swap returns the old map.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        if (!map_ready_q || bus.rd_row > LAST_ROW) rd_data_q <= '0;
        else if (rd_bank)                         rd_data_q <= mem1[bus.rd_row];
        else                                      rd_data_q <= mem0[bus.rd_row];
      end
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.map_ready  = map_ready_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_drop = frame_drop_q;
endmodule

// File: tb/tb_bin_map_scheduler.sv
// tb/tb_bin_map_scheduler.sv - directed bench with read-data scoreboard for bin_map_scheduler
module tb_bin_map_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_cnt = 0;
  int   drop_cnt = 0;
  int   d0, p0;
  logic [39:0] sb [$];
  logic [39:0] exp_word;

  always #5 clk = ~clk;

  bin_map_scheduler_if #(.WIDTH(40), .ROW_AW(7)) bus ();

  bin_map_scheduler #(.WIDTH(40), .ROWS(72)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic logic [39:0] pat(input int kind, input int r);
    logic [7:0] b;
    b = 8'(r);
    case (kind)
      0:       pat = 40'h92_4924_9249;
      1:       pat = 40'hFF_FFFF_FFFF;
      2:       pat = {5{b}};
      3:       pat = {5{~b}};
      4:       pat = {5{b ^ 8'hA5}};
      default: pat = {5{b + 8'h11}};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int kind, input int nrows);
    logic [39:0] w;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      w = pat(kind, r);
      for (int c = 0; c < 40; c++) begin
        bus.cell_valid = 1'b1;
        bus.cell_bin   = w[c];
        tick();
      end
    end
    bus.cell_valid = 1'b0;
    bus.cell_bin   = 1'b0;
  endtask

  task automatic read_row(input int r, input logic [39:0] e);
    bus.rd_req = 1'b1;
    bus.rd_row = 7'(r);
    sb.push_back(e);
    tick();
    bus.rd_req = 1'b0;
  endtask

  // Monitor: pops one expected word per rd_valid, counts status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_valid_unexpected", 64'd1, 64'd0);
        end else begin
          exp_word = sb.pop_front();
          chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_word});
        end
      end
      if (bus.frame_done) done_cnt++;
      if (bus.frame_drop) drop_cnt++;
    end
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.cell_valid  = 1'b0;
    bus.cell_bin    = 1'b0;
    bus.rd_lock     = 1'b0;
    bus.rd_req      = 1'b0;
    bus.rd_row      = '0;
    repeat (3) tick();
    chk("rst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 64'd0);
    chk("rst_map_ready", {63'd0, bus.map_ready}, 64'd0);
    chk("rst_frame_done", {63'd0, bus.frame_done}, 64'd0);
    chk("rst_frame_drop", {63'd0, bus.frame_drop}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: read before any frame returns zero
    read_row(0, 40'd0);
    tick();
    chk("t1_map_ready", {63'd0, bus.map_ready}, 64'd0);

    // 2: first frame commits into bank 0
    send_frame(0, 72);
    repeat (3) tick();
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_map_ready", {63'd0, bus.map_ready}, 64'd1);
    read_row(5, 40'h92_4924_9249);
    read_row(71, 40'h92_4924_9249);

    // 3: locked commit is deferred; reads keep returning frame A
    bus.rd_lock = 1'b1;
    send_frame(1, 72);
    repeat (3) tick();
    chk("t3_no_done_locked", 64'(done_cnt), 64'd1);
    read_row(0, 40'h92_4924_9249);
    read_row(40, 40'h92_4924_9249);
    bus.rd_lock = 1'b0;
    tick();
    chk("t3_frame_done_pulse", {63'd0, bus.frame_done}, 64'd1);
    tick();
    chk("t3_done_cnt", 64'(done_cnt), 64'd2);
    read_row(0, 40'hFF_FFFF_FFFF);
    read_row(71, 40'hFF_FFFF_FFFF);

    // 4: frame_start while locked drops B, C replaces it
    bus.rd_lock = 1'b1;
    send_frame(2, 72);
    repeat (2) tick();
    d0 = drop_cnt;
    send_frame(3, 72);
    repeat (2) tick();
    chk("t4_drop_cnt", 64'(drop_cnt), 64'(d0 + 1));
    chk("t4_no_done_locked", 64'(done_cnt), 64'd2);
    read_row(7, 40'hFF_FFFF_FFFF);
    bus.rd_lock = 1'b0;
    tick();
    chk("t4_frame_done_pulse", {63'd0, bus.frame_done}, 64'd1);
    tick();
    read_row(0, pat(3, 0));
    read_row(9, pat(3, 9));
    read_row(71, pat(3, 71));

    // 5: aborted partial frame leaves the reader bank alone
    p0 = done_cnt;
    d0 = drop_cnt;
    send_frame(4, 30);
    read_row(0, pat(3, 0));
    read_row(15, pat(3, 15));
    read_row(29, pat(3, 29));
    send_frame(5, 72);
    repeat (3) tick();
    chk("t5_done_cnt", 64'(done_cnt), 64'(p0 + 1));
    chk("t5_no_drop", 64'(drop_cnt), 64'(d0));
    read_row(0, pat(5, 0));
    read_row(29, pat(5, 29));
    read_row(71, pat(5, 71));

    // 6: out-of-range rows, then reset mid-fill
    read_row(72, 40'd0);
    read_row(127, 40'd0);
    tick();
    send_frame(2, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_map_ready_after_rst", {63'd0, bus.map_ready}, 64'd0);
    tick();
    read_row(3, 40'd0);
    p0 = done_cnt;
    send_frame(2, 72);
    repeat (3) tick();
    chk("t6_done_cnt", 64'(done_cnt), 64'(p0 + 1));
    chk("t6_map_ready", {63'd0, bus.map_ready}, 64'd1);
    read_row(3, pat(2, 3));
    read_row(70, pat(2, 70));

    repeat (4) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
